vc_credit_select: RTL and testbench

Parametrised, stateful successor to the router's unary VC-status selector: holds a credit counter for every (output port, VC) pair of one input port and reports blocked status (no credits). Takes a one-hot output-port select and a one-hot VC select, masks turns that are illegal under XY routing, and returns the registered blocked bit of the addressed VC. Sits between VC allocation and switch allocation in each input port of the VC router.

---
 rtl/vc_credit_pkg.sv | 36 +++
 rtl/vc_credit_select_counter.sv | 52 +++++
 rtl/vc_credit_select.sv | 112 +++++++++++
 tb/tb_vc_credit_select.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vc_credit_pkg.sv
// -----------------------------------------------------------------------------
// vc_credit_pkg
// Shared definitions for the VC credit selector: router port encoding and the
// XY-routing turn legality check.
// Optional feature macro: XY_TURN_FILTER_EN (enables the turn filter inside
// route_valid_turn; without it every turn is legal).
// -----------------------------------------------------------------------------
package vc_credit_pkg;

   typedef enum logic [2:0] {
      NORTH = 3'd0,
      EAST  = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      LOCAL = 3'd4
   } port_e;

`ifdef XY_TURN_FILTER_EN
   localparam bit XY_FILTER = 1'b1;
`else
   localparam bit XY_FILTER = 1'b0;
`endif

   // Under XY routing a packet never returns through its input port and a
   // packet already travelling in Y never turns back into X.
   function automatic logic route_valid_turn(input int unsigned in_port,
                                             input int unsigned out_port);
      logic w_same;
      logic w_yx;
      w_same = (out_port == in_port);
      w_yx   = ((in_port == int'(NORTH)) || (in_port == int'(SOUTH))) &&
               ((out_port == int'(EAST)) || (out_port == int'(WEST)));
      return !(XY_FILTER && (w_same || w_yx));
   endfunction

endpackage

// File: rtl/vc_credit_select_counter.sv
// -----------------------------------------------------------------------------
// vc_credit_counter
// One saturating credit counter for a single (output port, VC) pair.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset (counter -> DEPTH)
//   inc   in   credit returned
//   dec   in   decrement request (flit sent on this pair, legal turn)
//   zero  out  counter is 0 (pair blocked)
//   err   out  this cycle's request would overflow or underflow the counter
// -----------------------------------------------------------------------------
module vc_credit_counter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec,
   output logic zero,
   output logic err
);

   localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

   logic [CW-1:0] r_cnt;
   logic          w_zero;
   logic          w_full;
   logic          w_dec;
   logic          w_inc;

   assign w_zero = (r_cnt == '0);
   assign w_full = (r_cnt == LP_FULL);
   // A request at zero is dropped; a credit at full only counts when a
   // decrement cancels it (net unchanged), otherwise it is dropped.
   assign w_dec  = dec & ~w_zero;
   assign w_inc  = inc & ~(w_full & ~w_dec);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= LP_FULL;
      end else if (w_inc && !w_dec) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign zero = w_zero;
   assign err  = (dec & w_zero) | (inc & w_full & ~w_dec);

endmodule

// File: rtl/vc_credit_select.sv
// -----------------------------------------------------------------------------
// vc_credit_select
// Per-input-port credit tracker for every (output port, VC) pair. Reports
// blocked (no credit) status and answers one-hot select queries with a
// registered blocked bit. Illegal XY turns are masked when XY_TURN_FILTER_EN
// is defined.
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   sel_a          in   [NP]     output-port select (one-hot)
//   sel_b          in   [NV]     VC select (one-hot)
//   sel_valid      in   query strobe
//   flit_sent      in   consume one credit on the selected pair
//   credit_in      in   [NP*NV]  credit returns, bit i*NV+j = port i, VC j
//   blocked        out  [NP*NV]  counter k is zero
//   selected_bit   out  registered blocked status of queried pair(s)
//   selected_valid out  sel_valid delayed one cycle
//   credit_err     out  sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module vc_credit_select
   import vc_credit_pkg::*;
#(
   parameter int unsigned input_port = 0,
   parameter int unsigned NP         = 5,
   parameter int unsigned NV         = 4,
   parameter int unsigned BUF_DEPTH  = 4,
   parameter int unsigned CW         = $clog2(BUF_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NP-1:0]    sel_a,
   input  logic [NV-1:0]    sel_b,
   input  logic             sel_valid,
   input  logic             flit_sent,
   input  logic [NP*NV-1:0] credit_in,
   output logic [NP*NV-1:0] blocked,
   output logic             selected_bit,
   output logic             selected_valid,
   output logic             credit_err
);

   logic [NP-1:0]    w_legal;
   logic [NP*NV-1:0] w_addr;
   logic [NP*NV-1:0] w_dec_req;
   logic [NP*NV-1:0] w_zero;
   logic [NP*NV-1:0] w_err;
   logic             w_hit;

   logic             r_selected_bit;
   logic             r_selected_valid;
   logic             r_credit_err;

   always_comb begin
      w_legal = '0;
      for (int unsigned i = 0; i < NP; i++) begin
         w_legal[i] = route_valid_turn(input_port, i);
      end
   end

   // Addressed legal pairs; a non-one-hot select addresses several pairs.
   always_comb begin
      w_addr = '0;
      for (int unsigned i = 0; i < NP; i++) begin
         for (int unsigned j = 0; j < NV; j++) begin
            w_addr[i*NV + j] = sel_a[i] & sel_b[j] & w_legal[i];
         end
      end
   end

   assign w_dec_req = w_addr & {(NP*NV){flit_sent}};

   genvar g;
   generate
      for (g = 0; g < NP*NV; g++) begin : g_cnt
         vc_credit_counter #(
            .DEPTH (BUF_DEPTH),
            .CW    (CW)
         ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (credit_in[g]),
            .dec   (w_dec_req[g]),
            .zero  (w_zero[g]),
            .err   (w_err[g])
         );
      end
   endgenerate

   assign w_hit = |(w_zero & w_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_selected_bit   <= 1'b0;
         r_selected_valid <= 1'b0;
         r_credit_err     <= 1'b0;
      end else begin
         r_selected_valid <= sel_valid;
         if (sel_valid) begin
            r_selected_bit <= w_hit;
         end
         if (|w_err) begin
            r_credit_err <= 1'b1;
         end
      end
   end

   assign blocked        = w_zero;
   assign selected_bit   = r_selected_bit;
   assign selected_valid = r_selected_valid;
   assign credit_err     = r_credit_err;

endmodule

// File: tb/tb_vc_credit_select.sv
module tb_vc_credit_select;
   import vc_credit_pkg::*;

`ifdef XY_TURN_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   // DUT A: input_port = LOCAL
   logic [4:0]  a_sel_a;
   logic [3:0]  a_sel_b;
   logic        a_sv;
   logic        a_flit;
   logic [19:0] a_cin;
   logic [19:0] a_blk;
   logic        a_sb;
   logic        a_svo;
   logic        a_err;

   // DUT B: input_port = NORTH
   logic [4:0]  b_sel_a;
   logic [3:0]  b_sel_b;
   logic        b_sv;
   logic        b_flit;
   logic [19:0] b_cin;
   logic [19:0] b_blk;
   logic        b_sb;
   logic        b_svo;
   logic        b_err;

   int n_checks = 0;
   int n_errors = 0;
   logic q_a[$];
   logic q_b[$];

   vc_credit_select #(
      .input_port (int'(LOCAL)),
      .NP         (5),
      .NV         (4),
      .BUF_DEPTH  (4)
   ) u_dut_a (
      .clk            (clk),
      .rst_n          (rst_n),
      .sel_a          (a_sel_a),
      .sel_b          (a_sel_b),
      .sel_valid      (a_sv),
      .flit_sent      (a_flit),
      .credit_in      (a_cin),
      .blocked        (a_blk),
      .selected_bit   (a_sb),
      .selected_valid (a_svo),
      .credit_err     (a_err)
   );

   vc_credit_select #(
      .input_port (int'(NORTH)),
      .NP         (5),
      .NV         (4),
      .BUF_DEPTH  (4)
   ) u_dut_b (
      .clk            (clk),
      .rst_n          (rst_n),
      .sel_a          (b_sel_a),
      .sel_b          (b_sel_b),
      .sel_valid      (b_sv),
      .flit_sent      (b_flit),
      .credit_in      (b_cin),
      .blocked        (b_blk),
      .selected_bit   (b_sb),
      .selected_valid (b_svo),
      .credit_err     (b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Scoreboard monitors: pop expected query result whenever a response appears.
   always @(negedge clk) begin
      if (rst_n && a_svo) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_valid", 32'd1, 32'd0);
         end else begin
            chk("a_query", {31'd0, a_sb}, {31'd0, q_a.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_svo) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_valid", 32'd1, 32'd0);
         end else begin
            chk("b_query", {31'd0, b_sb}, {31'd0, q_b.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_sel_a = '0; a_sel_b = '0; a_sv = 1'b0; a_flit = 1'b0; a_cin = '0;
      b_sel_a = '0; b_sel_b = '0; b_sv = 1'b0; b_flit = 1'b0; b_cin = '0;
      repeat (2) tick();
      chk("rst_blocked", {12'd0, a_blk}, 32'd0);
      chk("rst_sel_bit", {31'd0, a_sb}, 32'd0);
      chk("rst_sel_valid", {31'd0, a_svo}, 32'd0);
      chk("rst_err", {31'd0, a_err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // first query on port 1 VC 0: credits full, not blocked
      a_sel_a = 5'b00010; a_sel_b = 4'b0001; a_sv = 1'b1; q_a.push_back(1'b0);
      tick();
      a_sv = 1'b0;
      chk("q1_blocked", {12'd0, a_blk}, 32'd0);

      // drain port 1 VC 0 (k=4)
      a_flit = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (n == 3) chk("drain3_blocked", {12'd0, a_blk}, 32'd0);
         if (n == 4) chk("drain4_blocked", {12'd0, a_blk}, 32'h10);
      end
      a_flit = 1'b0;
      chk("drain_no_err", {31'd0, a_err}, 32'd0);
      a_sv = 1'b1; q_a.push_back(1'b1);
      tick();
      a_sel_a = 5'b00011; a_sel_b = 4'b0011; q_a.push_back(1'b1);
      tick();
      a_sel_a = 5'b00010; a_sel_b = 4'b0010; q_a.push_back(1'b0);
      tick();
      a_sel_a = 5'b00000; a_sel_b = 4'b0000; q_a.push_back(1'b0);
      tick();
      a_sv = 1'b0;

      // underflow
      a_sel_a = 5'b00010; a_sel_b = 4'b0001; a_flit = 1'b1;
      tick();
      a_flit = 1'b0;
      chk("underflow_err", {31'd0, a_err}, 32'd1);
      chk("underflow_blocked", {12'd0, a_blk}, 32'h10);

      // flit_sent and credit return together at zero -> 1
      a_flit = 1'b1; a_cin = 20'h10;
      tick();
      a_flit = 1'b0; a_cin = '0;
      chk("simul_blocked", {12'd0, a_blk}, 32'd0);
      a_sv = 1'b1; q_a.push_back(1'b0);
      tick();
      a_sv = 1'b0; a_flit = 1'b1;
      tick();
      a_flit = 1'b0;
      chk("simul_cnt_one", {12'd0, a_blk}, 32'h10);

      // reset pulsed mid-drain on port 2 VC 3 (k=11)
      a_sel_a = 5'b00100; a_sel_b = 4'b1000; a_flit = 1'b1;
      a_sv = 1'b1; q_a.push_back(1'b0);
      tick();
      q_a.push_back(1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      a_sel_a = '0; a_sel_b = '0; a_sv = 1'b0; a_flit = 1'b0;
      #1;
      chk("async_sel_valid", {31'd0, a_svo}, 32'd0);
      chk("async_blocked", {12'd0, a_blk}, 32'd0);
      chk("async_err", {31'd0, a_err}, 32'd0);
      tick();
      rst_n = 1'b1;
      a_sel_a = 5'b00100; a_sel_b = 4'b1000; a_flit = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (n == 3) chk("redrain3_blocked", {12'd0, a_blk}, 32'd0);
         if (n == 4) chk("redrain4_blocked", {12'd0, a_blk}, 32'h800);
      end
      a_flit = 1'b0;

      // overflow on k=0 while full
      a_cin = 20'h1;
      tick();
      a_cin = '0;
      chk("overflow_err", {31'd0, a_err}, 32'd1);
      chk("overflow_blocked", {12'd0, a_blk}, 32'h800);
      a_sel_a = 5'b00001; a_sel_b = 4'b0001; a_flit = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (n == 3) chk("ovf_drain3_blocked", {12'd0, a_blk}, 32'h800);
         if (n == 4) chk("ovf_drain4_blocked", {12'd0, a_blk}, 32'h801);
      end
      a_flit = 1'b0; a_sel_a = '0; a_sel_b = '0;

      // DUT B (NORTH): EAST turn is illegal only with the turn filter
      b_sel_a = 5'b00010; b_sel_b = 4'b0001; b_flit = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (n == 1) chk("b_first_flit", {12'd0, b_blk}, 32'd0);
      end
      b_flit = 1'b0;
      chk("b_east_blocked", {12'd0, b_blk}, FILT ? 32'd0 : 32'h10);
      b_sv = 1'b1; q_b.push_back(!FILT);
      tick();
      b_sel_a = 5'b00011; q_b.push_back(!FILT);
      tick();
      b_sv = 1'b0;
      chk("b_err", {31'd0, b_err}, 32'd0);

      repeat (2) tick();
      chk("a_queue_empty", q_a.size(), 32'd0);
      chk("b_queue_empty", q_b.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
